// File: rtl/io_port_hub_disp.sv
// Port-I/O hub: synchronised input ports, R/W output registers, 4-digit 7-seg (hex or decimal).
// Latency: in_port 1 cycle after port_id (+2 sync for sw_in); writes same edge; decimal display 11 cycles.
// Backpressure: none; processor bus accesses always complete, repeated decimal starts queue as one pending.
module io_port_hub_disp #(
    parameter int          N_IN        = 1,
    parameter int          N_OUT       = 2,
    parameter logic [7:0]  IN_BASE     = 8'h01,
    parameter logic [7:0]  OUT_BASE    = 8'h03,
    parameter logic [7:0]  CTRL_ADDR   = 8'h0F,
    parameter int          REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic                 write_strobe,
    input  logic [7:0]           out_port,
    output logic [7:0]           in_port,
    input  logic [8*N_IN-1:0]    sw_in,
    output logic [8*N_OUT-1:0]   out_regs,
    output logic [3:0]           an,
    output logic [6:0]           seg
);

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  REF_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} conv_state_t;

    logic [8*N_IN-1:0] sw_meta;
    logic [8*N_IN-1:0] sw_sync;
    logic [7:0]        in_off;
    logic [7:0]        out_off;
    logic              in_hit;
    logic              out_hit;
    logic              ctrl_hit;
    logic [1:0]        ctrl;
    logic [7:0]        rd_dat;

    conv_state_t       state;
    conv_state_t       state_nxt;
    logic              conv_start;
    logic              conv_req;
    logic              do_load;
    logic              do_shift;
    logic              do_done;
    logic              take_req;
    logic [19:0]       scratch;
    logic [19:0]       scratch_adj;
    logic [2:0]        bit_cnt;
    logic [11:0]       bcd_q;

    logic [CW-1:0]     ref_cnt;
    logic [1:0]        dig_idx;
    logic              scan_live;
    logic [3:0][3:0]   dig;
    logic [3:0]        dig_on;
    logic [3:0]        cur_dig;
    logic              cur_on;
    logic [6:0]        seg_hi;

    // Address decode: offsets wrap in 8 bits so addresses below a base never hit its range.
    assign in_off   = port_id - IN_BASE;
    assign out_off  = port_id - OUT_BASE;
    assign in_hit   = (in_off < 8'(N_IN));
    assign out_hit  = (out_off < 8'(N_OUT));
    assign ctrl_hit = (port_id == CTRL_ADDR);

    // Two-flop synchroniser for the asynchronous board inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    // Processor writes into output registers and the display control register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_regs <= '0;
            ctrl     <= 2'b00;
        end else if (write_strobe) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (out_hit && (out_off == 8'(k))) begin
                    out_regs[8*k +: 8] <= out_port;
                end
            end
            if (ctrl_hit) begin
                ctrl <= out_port[1:0];
            end
        end
    end

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rd_dat = 8'h00;
        if (in_hit) begin
            for (int k = 0; k < N_IN; k++) begin
                if (in_off == 8'(k)) begin
                    rd_dat = sw_sync[8*k +: 8];
                end
            end
        end else if (out_hit) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (out_off == 8'(k)) begin
                    rd_dat = out_regs[8*k +: 8];
                end
            end
        end else if (ctrl_hit) begin
            rd_dat = {6'b0, ctrl};
        end
    end

    // Registered read data, updated every cycle regardless of strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_port <= 8'h00;
        end else begin
            in_port <= rd_dat;
        end
    end

    // A conversion is requested by a reg-0 write in decimal mode or a CTRL write selecting decimal.
    assign conv_start = write_strobe &&
                        ((out_hit && (out_off == 8'd0) && ctrl[0]) || (ctrl_hit && out_port[0]));

    // Request flag doubles as the pending marker while a conversion is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            conv_req <= 1'b0;
        end else if (conv_start) begin
            conv_req <= 1'b1;
        end else if (take_req) begin
            conv_req <= 1'b0;
        end
    end

    // Converter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Converter next-state logic; DONE chains straight into LOAD when a request is pending.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (conv_req) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (bit_cnt == 3'd7) state_nxt = S_DONE;
            S_DONE:  state_nxt = conv_req ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Converter control outputs.
    always_comb begin
        do_load  = (state == S_LOAD);
        do_shift = (state == S_SHIFT);
        do_done  = (state == S_DONE);
        take_req = ((state == S_IDLE) || (state == S_DONE)) && conv_req;
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more before shifting.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[8 + 4*i +: 4] >= 4'd5) begin
                scratch_adj[8 + 4*i +: 4] = scratch[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter datapath; the displayed BCD only changes at DONE so partial values never show.
    always_ff @(posedge clk) begin
        if (reset) begin
            scratch <= '0;
            bit_cnt <= 3'd0;
            bcd_q   <= 12'h000;
        end else begin
            if (do_load) begin
                scratch <= {12'h000, out_regs[7:0]};
                bit_cnt <= 3'd0;
            end
            if (do_shift) begin
                scratch <= {scratch_adj[18:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (do_done) begin
                bcd_q <= scratch[19:8];
            end
        end
    end

    // Digit scan: each digit stays lit for REFRESH_DIV cycles; display stays dark until reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt   <= '0;
            dig_idx   <= 2'd0;
            scan_live <= 1'b0;
        end else begin
            scan_live <= 1'b1;
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                dig_idx <= dig_idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + CW'(1);
            end
        end
    end

    // Digit selection: hex of regs 1:0, or decimal with leading-zero blanking and the top digit off.
    always_comb begin
        if (!ctrl[0]) begin
            dig    = out_regs[15:0];
            dig_on = 4'b1111;
        end else begin
            dig    = {4'h0, bcd_q};
            dig_on = {1'b0, (bcd_q[11:8] != 4'h0), (bcd_q[11:4] != 8'h00), 1'b1};
        end
        cur_dig = dig[dig_idx];
        cur_on  = scan_live && !ctrl[1] && dig_on[dig_idx];
    end

    // Hex to 7-segment decode, active-high gfedcba.
    always_comb begin
        case (cur_dig)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            default: seg_hi = 7'h71;
        endcase
    end

    assign an  = cur_on ? ~(4'b0001 << dig_idx) : 4'hF;
    assign seg = cur_on ? ~seg_hi : 7'h7F;

endmodule

// File: tb/tb_io_port_hub_disp.sv
// Self-checking bench for io_port_hub_disp: directed scenarios plus randomized bus traffic.
// Reference model tracks registers, a 2-deep input delay line and the display as plain arithmetic.
// All outputs are sampled on the falling edge; inputs change only on the falling edge.
module tb_io_port_hub_disp;

    localparam int         N_IN   = 2;
    localparam int         N_OUT  = 3;
    localparam int         DIV    = 3;
    localparam logic [7:0] IN_B   = 8'h01;
    localparam logic [7:0] OUT_B  = 8'h03;
    localparam logic [7:0] CTRL_A = 8'h0F;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [7:0]          port_id = 8'h00;
    logic                write_strobe = 1'b0;
    logic [7:0]          out_port = 8'h00;
    logic [7:0]          in_port;
    logic [8*N_IN-1:0]   sw_in = '0;
    logic [8*N_OUT-1:0]  out_regs;
    logic [3:0]          an;
    logic [6:0]          seg;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]          m_out [N_OUT];
    logic [1:0]          m_ctrl = 2'b00;
    logic [7:0]          m_in = 8'h00;
    logic [8*N_IN-1:0]   sw_d1 = '0;
    logic [8*N_IN-1:0]   sw_d2 = '0;
    int                  k = 0;

    // display checking controls
    bit disp_on = 1'b0;
    bit rand_phase = 1'b0;
    int dv_set [3];
    int n_dv = 1;

    always #5 clk = ~clk;

    io_port_hub_disp #(
        .N_IN(N_IN), .N_OUT(N_OUT), .IN_BASE(IN_B), .OUT_BASE(OUT_B),
        .CTRL_ADDR(CTRL_A), .REFRESH_DIV(DIV)
    ) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
        .out_port(out_port), .in_port(in_port), .sw_in(sw_in), .out_regs(out_regs),
        .an(an), .seg(seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_map(input logic [7:0] pid, input logic [8*N_IN-1:0] sync);
        int p;
        p = int'(pid);
        if (p >= int'(IN_B) && p < int'(IN_B) + N_IN) return sync[8*(p-int'(IN_B)) +: 8];
        if (p >= int'(OUT_B) && p < int'(OUT_B) + N_OUT) return m_out[p-int'(OUT_B)];
        if (pid == CTRL_A) return {6'b0, m_ctrl};
        return 8'h00;
    endfunction

    // behavioural model, advanced on every rising edge from the inputs the bench is driving
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) m_out[i] = 8'h00;
            m_ctrl = 2'b00;
            m_in   = 8'h00;
            sw_d1  = '0;
            sw_d2  = '0;
            k      = 0;
        end else begin
            m_in  = rd_map(port_id, sw_d2);
            sw_d2 = sw_d1;
            sw_d1 = sw_in;
            if (write_strobe) begin
                if (int'(port_id) >= int'(OUT_B) && int'(port_id) < int'(OUT_B) + N_OUT)
                    m_out[int'(port_id) - int'(OUT_B)] = out_port;
                if (port_id == CTRL_A) m_ctrl = out_port[1:0];
            end
            k = k + 1;
        end
    end

    function automatic logic [6:0] seg_hi(input logic [3:0] d);
        case (d)
            4'h0: return 7'b0111111; 4'h1: return 7'b0000110;
            4'h2: return 7'b1011011; 4'h3: return 7'b1001111;
            4'h4: return 7'b1100110; 4'h5: return 7'b1101101;
            4'h6: return 7'b1111101; 4'h7: return 7'b0000111;
            4'h8: return 7'b1111111; 4'h9: return 7'b1101111;
            4'hA: return 7'b1110111; 4'hB: return 7'b1111100;
            4'hC: return 7'b0111001; 4'hD: return 7'b1011110;
            4'hE: return 7'b1111001; default: return 7'b1110001;
        endcase
    endfunction

    // expected {an,seg} from cycles since reset release, control bits, hex regs and the decimal value shown
    function automatic logic [10:0] exp_disp(input int kk, input logic [1:0] c,
                                             input logic [7:0] o0, input logic [7:0] o1, input int dv);
        int idx;
        logic [3:0] d;
        logic [3:0] an_e;
        bit on;
        if (kk < 1 || c[1]) return {4'hF, 7'h7F};
        idx = (kk / DIV) % 4;
        on = 1'b1;
        d = 4'h0;
        if (!c[0]) begin
            case (idx)
                0: d = o0[3:0];
                1: d = o0[7:4];
                2: d = o1[3:0];
                default: d = o1[7:4];
            endcase
        end else begin
            case (idx)
                0: d = 4'(dv % 10);
                1: begin d = 4'((dv / 10) % 10); on = (dv >= 10); end
                2: begin d = 4'(dv / 100); on = (dv >= 100); end
                default: on = 1'b0;
            endcase
        end
        if (!on) return {4'hF, 7'h7F};
        an_e = 4'hF;
        an_e[idx] = 1'b0;
        return {an_e, ~seg_hi(d)};
    endfunction

    task automatic tick();
        logic [8*N_OUT-1:0] exp_regs;
        logic [10:0] e;
        logic [10:0] cand;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N_OUT; i++) exp_regs[8*i +: 8] = m_out[i];
        check("in_port", 32'(in_port), 32'(m_in));
        check("out_regs", 32'(out_regs), 32'(exp_regs));
        if (disp_on && (!rand_phase || !m_ctrl[0] || m_ctrl[1])) begin
            e = exp_disp(k, m_ctrl, m_out[0], m_out[1], dv_set[0]);
            for (int j = 1; j < n_dv; j++) begin
                cand = exp_disp(k, m_ctrl, m_out[0], m_out[1], dv_set[j]);
                if (cand == {an, seg}) e = cand;
            end
            check("display", 32'({an, seg}), 32'(e));
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        port_id = addr;
        out_port = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        reset = 1'b1;
        tick();
        tick();
        check("rst_in_port", 32'(in_port), 32'h0);
        check("rst_out_regs", 32'(out_regs), 32'h0);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);

        // scan order after release in hex mode
        reset = 1'b0;
        disp_on = 1'b1;
        n_dv = 1;
        dv_set[0] = 0;
        repeat (14) tick();

        // synchronised inputs and unmapped read
        sw_in = 16'h3CA5;
        port_id = IN_B;
        repeat (3) tick();
        check("sw_port0", 32'(in_port), 32'hA5);
        port_id = 8'h40;
        tick();
        check("unmapped_rd", 32'(in_port), 32'h00);
        port_id = IN_B + 8'd1;
        tick();
        check("sw_port1", 32'(in_port), 32'h3C);

        // hex display of regs 1:0 and readback
        wr(OUT_B, 8'h34);
        wr(OUT_B + 8'd1, 8'h12);
        port_id = OUT_B;
        tick();
        check("out16", 32'(out_regs[15:0]), 32'h1234);
        check("readback", 32'(in_port), 32'h34);
        repeat (14) tick();

        // decimal mode: CTRL write converts 0x34 = 52
        n_dv = 2; dv_set[0] = 0; dv_set[1] = 52;
        wr(CTRL_A, 8'h01);
        port_id = CTRL_A;
        tick();
        check("ctrl_rd", 32'(in_port), 32'h01);
        repeat (14) tick();
        n_dv = 1; dv_set[0] = 52;
        for (int i = 0; i < 12 && (k % 12) != 2; i++) tick();
        // ones digit is lit on both the 10th and 11th edge after this write
        wr(OUT_B, 8'd255);
        for (int n = 1; n <= 14; n++) begin
            dv_set[0] = (n >= 11) ? 255 : 52;
            tick();
        end
        n_dv = 2; dv_set[0] = 255; dv_set[1] = 7;
        wr(OUT_B, 8'd7);
        repeat (14) tick();
        n_dv = 1; dv_set[0] = 7;
        repeat (12) tick();

        // back-to-back starts: only complete values may appear, 9 wins
        n_dv = 3; dv_set[0] = 7; dv_set[1] = 200; dv_set[2] = 9;
        wr(OUT_B, 8'd200);
        repeat (3) tick();
        wr(OUT_B, 8'd9);
        repeat (30) tick();
        n_dv = 1; dv_set[0] = 9;
        repeat (12) tick();

        // reset during SHIFT aborts and clears the result
        n_dv = 2; dv_set[0] = 9; dv_set[1] = 123;
        wr(OUT_B, 8'd123);
        repeat (4) tick();
        reset = 1'b1;
        disp_on = 1'b0;
        tick();
        check("midrst_regs", 32'(out_regs), 32'h0);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_in", 32'(in_port), 32'h0);
        reset = 1'b0;
        disp_on = 1'b1;
        n_dv = 1; dv_set[0] = 0;
        repeat (3) tick();
        wr(CTRL_A, 8'h01);
        repeat (14) tick();
        wr(CTRL_A, 8'h02);
        repeat (15) tick();
        check("blank_an", 32'(an), 32'hF);

        // randomized traffic, decimal display compared once the converter has settled
        for (int b = 0; b < 10; b++) begin
            rand_phase = 1'b1;
            for (int c = 0; c < 30; c++) begin
                case ($urandom_range(0, 9))
                    0, 1: port_id = IN_B + 8'($urandom_range(0, N_IN - 1));
                    2, 3, 4, 5: port_id = OUT_B + 8'($urandom_range(0, N_OUT - 1));
                    6: port_id = CTRL_A;
                    default: port_id = 8'($urandom_range(0, 255));
                endcase
                out_port = 8'($urandom_range(0, 255));
                write_strobe = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) sw_in = 16'($urandom_range(0, 65535));
                tick();
            end
            write_strobe = 1'b0;
            repeat (30) tick();
            rand_phase = 1'b0;
            dv_set[0] = int'(m_out[0]);
            repeat (12) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
